// File: rtl/uart_cmd_master.sv
// uart_cmd_master: UART command master. Sends a CMD_BYTES command MSB byte first, each byte LSB first as 8N1/8O1/8E1.
//   For reads (command MSB = 0) it then collects RD_BYTES response frames and returns them with an error flag.
//   Ports: clk, rst_n (async, active-low); cmd_in/cmd_vld/cmd_rdy command handshake; tx/rx UART pins;
//   read_vld/read_data/read_err read result (data and error held until the next read_vld); busy = ~cmd_rdy.
//   Optional macro UART_CMD_RX_TIMEOUT_EN: give up waiting for the first response byte after RX_TIMEOUT cycles.
module uart_cmd_master #(
  parameter int CLK_DIV    = 434,
  parameter int CMD_BYTES  = 2,
  parameter int RD_BYTES   = 1,
  parameter int PARITY     = 1,
  parameter int GAP_CYCLES = 100,
  parameter int RX_TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CMD_BYTES*8-1:0] cmd_in,
  input  logic                   cmd_vld,
  output logic                   cmd_rdy,
  output logic                   tx,
  input  logic                   rx,
  output logic                   read_vld,
  output logic [RD_BYTES*8-1:0]  read_data,
  output logic                   read_err,
  output logic                   busy
);
  localparam int CMAX = CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = RD_BYTES * 8;
  localparam logic [CW-1:0] BIT_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
  if (CLK_DIV < 4 || CMD_BYTES < 1 || CMD_BYTES > 4 || RD_BYTES < 1 || RD_BYTES > 4 ||
      PARITY < 0 || PARITY > 2 || GAP_CYCLES < 0 || RX_TIMEOUT < 1) begin : g_bad_param
    $error("uart_cmd_master: parameter out of range");
  end
  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, GAP,
    RX_WAIT, RX_START, RX_DATA, RX_PAR, RX_STOP, DONE
  } state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [CMD_BYTES*8-1:0] cmd_q, cmd_d;
  logic wr_q, wr_d;
  logic rx1_q, rx2_q, rxp_q;
  logic [7:0] rsh_q, rsh_d;
  logic [RW-1:0] acc_q, acc_d, rdat_q, rdat_d;
  logic err_q, err_d, rerr_q, rerr_d;
  logic bit_end, half_end, gap_end, tx_last, rx_last, fall, tmo_hit;
  logic par_bad, err_any, done_in, tx_par;
  logic [7:0] tx_byte;
  assign bit_end  = cnt_q == BIT_END;
  assign half_end = cnt_q == HALF_END;
  assign gap_end  = cnt_q == GAP_END;
  // The byte on the wire is always the top byte; cmd_q shifts left after each stop bit.
  assign tx_byte  = cmd_q[CMD_BYTES*8-1 -: 8];
  assign tx_par   = (PARITY == 1) ? ~^tx_byte : ^tx_byte;
  assign tx_last  = byte_q == 2'(CMD_BYTES - 1);
  assign rx_last  = byte_q == 2'(RD_BYTES - 1);
  assign fall     = rxp_q & ~rx2_q;
  assign par_bad  = (^{rsh_q, rx2_q}) != (PARITY == 1);
  assign err_any  = err_q | (state_q == RX_PAR && bit_end && par_bad) | (state_q == RX_STOP && bit_end && !rx2_q);
  assign done_in  = state_d == DONE;
  assign read_data = rdat_q;
  assign read_err  = rerr_q;
`ifdef UART_CMD_RX_TIMEOUT_EN
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // Restarts from zero every time RX_WAIT is entered; only the first response byte can time out.
  assign tmo_d   = state_q == RX_WAIT ? tmo_q + TW'(1) : '0;
  assign tmo_hit = state_q == RX_WAIT && byte_q == 2'd0 && tmo_q == TW'(RX_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = cmd_vld ? TX_START : IDLE;
      TX_START: state_d = bit_end ? TX_DATA : TX_START;
      TX_DATA:  state_d = (bit_end && bit_q == 3'd7) ? (PARITY != 0 ? TX_PAR : TX_STOP) : TX_DATA;
      TX_PAR:   state_d = bit_end ? TX_STOP : TX_PAR;
      TX_STOP:  if (bit_end) state_d = !tx_last ? (GAP_CYCLES > 0 ? GAP : TX_START) : wr_q ? IDLE : RX_WAIT;
      GAP:      state_d = gap_end ? TX_START : GAP;
      RX_WAIT:  state_d = tmo_hit ? DONE : fall ? RX_START : RX_WAIT;
      RX_START: if (half_end) state_d = rx2_q ? RX_WAIT : RX_DATA;
      RX_DATA:  state_d = (bit_end && bit_q == 3'd7) ? (PARITY != 0 ? RX_PAR : RX_STOP) : RX_DATA;
      RX_PAR:   state_d = bit_end ? RX_STOP : RX_PAR;
      RX_STOP:  if (bit_end) state_d = rx_last ? DONE : RX_WAIT;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    cmd_rdy  = state_q == IDLE;
    busy     = state_q != IDLE;
    read_vld = state_q == DONE;
    tx = state_q == TX_START ? 1'b0 : state_q == TX_DATA ? tx_byte[bit_q] : state_q == TX_PAR ? tx_par : 1'b1;
  end
  // The shared counter restarts on every state change; inside GAP it runs to GAP_END instead of bit length.
  // After RX_START the counter is mid-bit, so a full bit period later lands mid-bit again.
  always_comb begin
    cnt_d  = (state_d != state_q || (state_q != GAP && bit_end)) ? '0 : cnt_q + CW'(1);
    bit_d  = ((state_q == TX_DATA || state_q == RX_DATA) && bit_end) ? bit_q + 3'd1 : bit_q;
    byte_d = (state_q == IDLE || (state_q == TX_STOP && state_d == RX_WAIT)) ? 2'd0 :
             ((state_q == TX_STOP || state_q == RX_STOP) && bit_end) ? byte_q + 2'd1 : byte_q;
    cmd_d  = (state_q == IDLE && cmd_vld) ? cmd_in : (state_q == TX_STOP && bit_end) ? cmd_q << 8 : cmd_q;
    wr_d   = (state_q == IDLE && cmd_vld) ? cmd_in[CMD_BYTES*8-1] : wr_q;
    rsh_d  = (state_q == RX_DATA && bit_end) ? {rx2_q, rsh_q[7:1]} : rsh_q;
    acc_d  = (state_q == RX_STOP && bit_end) ? RW'({acc_q, rsh_q}) : acc_q;
    err_d  = done_in ? 1'b0 : err_any;
    // A timeout reaches DONE straight from RX_WAIT and must leave the previous data in place.
    rdat_d = (done_in && state_q != RX_WAIT) ? acc_d : rdat_q;
    rerr_d = done_in ? (err_any | (state_q == RX_WAIT)) : rerr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      cmd_q  <= '0;
      wr_q   <= 1'b0;
      rx1_q  <= 1'b1;
      rx2_q  <= 1'b1;
      rxp_q  <= 1'b1;
      rsh_q  <= '0;
      acc_q  <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      cmd_q  <= cmd_d;
      wr_q   <= wr_d;
      rx1_q  <= rx;
      rx2_q  <= rx1_q;
      rxp_q  <= rx2_q;
      rsh_q  <= rsh_d;
      acc_q  <= acc_d;
      rdat_q <= rdat_d;
      err_q  <= err_d;
      rerr_q <= rerr_d;
    end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: directed bench for uart_cmd_master (CLK_DIV=8, 2 command bytes, 1 response byte, odd parity,
//   10-cycle gap, RX_TIMEOUT=200). The expected tx waveform is built from the frame format as a per-cycle queue;
//   read results are predicted per transaction and checked whenever read_vld fires.
module tb_uart_cmd_master;
  localparam int CLK_DIV = 8;
  localparam int GAP = 10;
  logic clk = 1'b0, rst_n = 1'b1, cmd_vld = 1'b0, rx = 1'b1;
  logic [15:0] cmd_in = '0;
  logic cmd_rdy, tx, read_vld, read_err, busy;
  logic [7:0] read_data;
  int n_vec = 0, n_err = 0;
  bit exp_tx[$];
  bit rd_pend = 1'b0;
  logic [7:0] exp_data = '0, held_data = '0;
  logic exp_err = 1'b0;

  uart_cmd_master #(.CLK_DIV(CLK_DIV), .CMD_BYTES(2), .RD_BYTES(1), .PARITY(1), .GAP_CYCLES(GAP), .RX_TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .tx(tx), .rx(rx),
    .read_vld(read_vld), .read_data(read_data), .read_err(read_err), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_bit(input bit b, input int n);
    for (int i = 0; i < n; i++) exp_tx.push_back(b);
  endtask

  task automatic send_cmd(input logic [15:0] w);
    logic [7:0] d;
    @(negedge clk);
    cmd_in = w;
    cmd_vld = 1'b1;
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    cmd_in = 16'($urandom);
    for (int b = 0; b < 2; b++) begin
      d = w[15-8*b -: 8];
      push_bit(1'b0, CLK_DIV);
      for (int i = 0; i < 8; i++) push_bit(d[i], CLK_DIV);
      push_bit(~^d, CLK_DIV);
      push_bit(1'b1, CLK_DIV);
      if (b == 0) push_bit(1'b1, GAP);
    end
  endtask

  task automatic wait_tx();
    for (int i = 0; i < 400 && exp_tx.size() > 0; i++) @(negedge clk);
    chk("tx_drained", exp_tx.size(), 0);
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] c, input logic [7:0] d, input bit bad, input bit glitch);
    exp_data = d;
    exp_err = bad;
    rd_pend = 1'b1;
    send_cmd(c);
    wait_tx();
    repeat (3) @(negedge clk);
    if (glitch) begin
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
    end
    rx_frame(d, bad);
    for (int i = 0; i < 100 && rd_pend; i++) @(negedge clk);
    chk("rd_vld_seen", rd_pend, 0);
    @(negedge clk);
    chk("rd_idle", cmd_rdy, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_rdy", 32'(busy ^ cmd_rdy), 1);
      if (exp_tx.size() > 0) begin
        chk("tx_bit", tx, exp_tx.pop_front());
        chk("rdy_low", cmd_rdy, 0);
      end else chk("tx_idle", tx, 1);
      if (rd_pend && read_vld) begin
        chk("rd_data", read_data, exp_data);
        chk("rd_err", read_err, exp_err);
        held_data = exp_data;
        rd_pend = 1'b0;
      end else begin
        if (!rd_pend) chk("spurious_rd_vld", read_vld, 0);
        chk("rd_hold", read_data, held_data);
      end
    end
  end

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_rdy", cmd_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_vld", read_vld, 0);
    chk("rst_data", read_data, 0);
    chk("rst_err", read_err, 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // write 8A5C with spot checks of both parity bits and a command offered while busy
    send_cmd(16'h8A5C);
    repeat (76) @(negedge clk);
    chk("par_8A", tx, 0);
    cmd_in = 16'h1234;
    cmd_vld = 1'b1;
    repeat (5) @(negedge clk);
    cmd_vld = 1'b0;
    repeat (94) @(negedge clk);
    chk("par_5C", tx, 1);
    repeat (12) @(negedge clk);
    chk("wr_done_rdy", cmd_rdy, 1);
    repeat (5) @(negedge clk);
    do_read(16'h0012, 8'h3C, 1'b0, 1'b0);
    do_read(16'h0012, 8'h3C, 1'b1, 1'b0);
    do_read(16'h0077, 8'hA7, 1'b0, 1'b0);
    do_read(16'h0012, 8'h55, 1'b0, 1'b1);
    // reset in the middle of a data bit
    send_cmd(16'h5AF0);
    repeat (30) @(negedge clk);
    #1;
    exp_tx.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_rdy", cmd_rdy, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", read_data, 0);
    held_data = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send_cmd(16'hC3A1);
    wait_tx();
    @(negedge clk);
    chk("post_rst_rdy", cmd_rdy, 1);
`ifdef UART_CMD_RX_TIMEOUT_EN
    exp_data = held_data;
    exp_err = 1'b1;
    rd_pend = 1'b1;
    send_cmd(16'h0034);
    n = 0;
    while (!read_vld && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycle", n, 187 + 200);
    @(negedge clk);
    chk("tmo_idle", cmd_rdy, 1);
`else
    send_cmd(16'h0034);
    repeat (500) @(negedge clk);
    chk("no_tmo_busy", busy, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("dead_link_rst", cmd_rdy, 1);
    held_data = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
